// File: rtl/uart_line_echo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_line_echo_ctrl
// Purpose  : Collects a line of UART RX bytes (with backspace editing) and
//            echoes it back on TX followed by CR LF.
// Revision : 1.0 - initial release
// ============================================================================
module uart_line_echo_ctrl #(
    parameter int LINE_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_next,
    output logic [7:0] tx_data,
    output logic       tx_en,
    input  logic       tx_full,
    output logic       busy,
    output logic       ovf
);

    localparam int            CW     = $clog2(LINE_LEN + 1);
    localparam int            AW     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(LINE_LEN - 1);
    localparam logic [7:0]    c_CR   = 8'h0D;
    localparam logic [7:0]    c_LF   = 8'h0A;
    localparam logic [7:0]    c_BS   = 8'h08;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        SEND_CR = 2'd2,
        SEND_LF = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_idx;
    logic          r_rx_next;
    logic          r_tx_en;
    logic [7:0]    r_tx_data;
    logic          r_ovf;
    logic [7:0]    r_buf [LINE_LEN];

    logic          w_take;
    logic          w_is_char;
    logic          w_store;
    logic [CW-1:0] w_cnt_m1;

    // A pop is blocked in the cycle rx_next is high so the FWFT head can advance.
    assign w_take    = (r_state == COLLECT) && !rx_empty && !r_rx_next;
    assign w_is_char = (rx_data != c_CR) && (rx_data != c_LF) && (rx_data != c_BS);
    assign w_store   = w_take && w_is_char;
    assign w_cnt_m1  = r_cnt - 1'b1;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_cnt[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rx_next <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
            r_ovf     <= 1'b0;
        end else begin
            r_rx_next <= 1'b0;
            r_tx_en   <= 1'b0;
            r_ovf     <= 1'b0;
            case (r_state)
                COLLECT: begin
                    r_idx <= '0;
                    if (w_take) begin
                        r_rx_next <= 1'b1;
                        if (rx_data == c_CR) begin
                            r_state <= SEND;
                        end else if (rx_data == c_BS) begin
                            if (r_cnt != '0) begin
                                r_cnt <= w_cnt_m1;
                            end
                        end else if (rx_data != c_LF) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == c_LAST) begin
                                r_ovf   <= 1'b1;
                                r_state <= SEND;
                            end
                        end
                    end
                end
                SEND: begin
                    if (r_cnt == '0) begin
                        r_state <= SEND_CR;
                    end else if (!tx_full) begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= r_buf[r_idx[AW-1:0]];
                        r_idx     <= r_idx + 1'b1;
                        if (r_idx == w_cnt_m1) begin
                            r_state <= SEND_CR;
                        end
                    end
                end
                SEND_CR: begin
                    if (!tx_full) begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= c_CR;
                        r_state   <= SEND_LF;
                    end
                end
                SEND_LF: begin
                    if (!tx_full) begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= c_LF;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_state   <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign rx_next = r_rx_next;
    assign tx_en   = r_tx_en;
    assign tx_data = r_tx_data;
    assign ovf     = r_ovf;
    assign busy    = (r_state != COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_uart_line_echo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_line_echo_ctrl
// Purpose  : Directed self-checking bench for uart_line_echo_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_line_echo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_next;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_full = 1'b0;
    logic       busy;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    // RX FIFO model (first-word fall-through)
    logic [7:0] rxmem [64];
    int         rx_wr = 0;
    int         rx_rd = 0;
    int         pop_err = 0;

    // TX capture and protocol monitors
    logic [7:0] txcap [64];
    int         tx_n = 0;
    int         ovf_n = 0;
    int         full_viol = 0;
    int         b2b_viol = 0;
    logic       full_at_edge = 1'b0;
    logic       prev_rx_next = 1'b0;

    assign rx_empty = (rx_rd == rx_wr);
    assign rx_data  = rxmem[rx_rd % 64];

    always #5 clk = ~clk;

    uart_line_echo_ctrl #(.LINE_LEN(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_empty(rx_empty),
        .rx_next (rx_next),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .tx_full (tx_full),
        .busy    (busy),
        .ovf     (ovf)
    );

    always @(posedge clk) begin
        full_at_edge <= tx_full;
        if (rx_next) begin
            if (rx_rd == rx_wr) pop_err <= pop_err + 1;
            else                rx_rd   <= rx_rd + 1;
        end
    end

    always @(negedge clk) begin
        if (tx_en) begin
            if (tx_n < 64) txcap[tx_n] = tx_data;
            tx_n = tx_n + 1;
            if (full_at_edge) full_viol = full_viol + 1;
        end
        if (ovf) ovf_n = ovf_n + 1;
        if (rx_next && prev_rx_next) b2b_viol = b2b_viol + 1;
        prev_rx_next = rx_next;
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rxmem[rx_wr % 64] = s[i];
            rx_wr = rx_wr + 1;
        end
    endtask

    task automatic clear_cap();
        tx_n  = 0;
        ovf_n = 0;
    endtask

    // Bounded wait for n pushes and return to COLLECT; timeout counts as a failure.
    task automatic wait_done(input int n, input string name);
        int cyc;
        cyc = 0;
        while (!(tx_n >= n && busy == 1'b0 && rx_empty) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 1000) begin
            bad++;
            $display("FAIL %s timeout: got %0d pushes, wanted %0d", name, tx_n, n);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_next !== 1'b0)  begin bad++; $display("FAIL reset_rx_next got=%b exp=0", rx_next); end
        total++; if (tx_en   !== 1'b0)  begin bad++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (ovf     !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        total++; if (busy    !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hi();
        string e;
        e = "Hi\015\012";
        clear_cap();
        push_str("Hi\015");
        wait_done(e.len(), "hi");
        total++; if (tx_n !== e.len()) begin bad++; $display("FAIL hi_count got=%0d exp=%0d", tx_n, e.len()); end
        for (int i = 0; i < e.len(); i++) begin
            total++;
            if (txcap[i] !== e[i]) begin bad++; $display("FAIL hi_byte%0d got=%h exp=%h", i, txcap[i], e[i]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hi_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backspace();
        string e;
        e = "ac\015\012";
        clear_cap();
        push_str("ab\010c\015");
        wait_done(e.len(), "bs");
        total++; if (tx_n !== e.len()) begin bad++; $display("FAIL bs_count got=%0d exp=%0d", tx_n, e.len()); end
        for (int i = 0; i < e.len(); i++) begin
            total++;
            if (txcap[i] !== e[i]) begin bad++; $display("FAIL bs_byte%0d got=%h exp=%h", i, txcap[i], e[i]); end
        end
    endtask

    task automatic test_overflow();
        string e;
        e = "0123456789ABCDEF\015\012";
        clear_cap();
        push_str("0123456789ABCDEF");
        wait_done(e.len(), "ovf");
        total++; if (ovf_n !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d exp=1", ovf_n); end
        total++; if (tx_n !== e.len()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", tx_n, e.len()); end
        for (int i = 0; i < e.len(); i++) begin
            total++;
            if (txcap[i] !== e[i]) begin bad++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, txcap[i], e[i]); end
        end
    endtask

    task automatic test_tx_full_hold();
        string e;
        int cyc;
        int held;
        e = "xyz\015\012";
        clear_cap();
        push_str("xyz\015");
        cyc = 0;
        while (tx_en !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc >= 200) begin bad++; $display("FAIL hold_first_push timeout got=none exp=push"); end
        tx_full = 1'b1;
        held = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_en) held++;
        end
        total++; if (held !== 0) begin bad++; $display("FAIL hold_tx_en got=%0d pushes exp=0", held); end
        total++; if (tx_data !== 8'h78) begin bad++; $display("FAIL hold_tx_data got=%h exp=78", tx_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
        tx_full = 1'b0;
        wait_done(e.len(), "hold");
        total++; if (tx_n !== e.len()) begin bad++; $display("FAIL hold_count got=%0d exp=%0d", tx_n, e.len()); end
        for (int i = 0; i < e.len(); i++) begin
            total++;
            if (txcap[i] !== e[i]) begin bad++; $display("FAIL hold_byte%0d got=%h exp=%h", i, txcap[i], e[i]); end
        end
    endtask

    task automatic test_empty_lines();
        clear_cap();
        push_str("\015");
        wait_done(2, "cr_only");
        total++; if (tx_n !== 2) begin bad++; $display("FAIL cr_only_count got=%0d exp=2", tx_n); end
        total++; if (txcap[0] !== 8'h0D) begin bad++; $display("FAIL cr_only_b0 got=%h exp=0d", txcap[0]); end
        total++; if (txcap[1] !== 8'h0A) begin bad++; $display("FAIL cr_only_b1 got=%h exp=0a", txcap[1]); end
        clear_cap();
        push_str("\010\015");
        wait_done(2, "bs_cr");
        total++; if (tx_n !== 2) begin bad++; $display("FAIL bs_cr_count got=%0d exp=2", tx_n); end
        total++; if (txcap[0] !== 8'h0D) begin bad++; $display("FAIL bs_cr_b0 got=%h exp=0d", txcap[0]); end
        total++; if (txcap[1] !== 8'h0A) begin bad++; $display("FAIL bs_cr_b1 got=%h exp=0a", txcap[1]); end
        // A following one-char line proves cnt stayed at zero rather than wrapping.
        clear_cap();
        push_str("q\015");
        wait_done(3, "after_bs");
        total++; if (tx_n !== 3) begin bad++; $display("FAIL after_bs_count got=%0d exp=3", tx_n); end
        total++; if (txcap[0] !== 8'h71) begin bad++; $display("FAIL after_bs_b0 got=%h exp=71", txcap[0]); end
    endtask

    task automatic test_reset_mid_send();
        string e;
        int seen;
        int cyc;
        int during;
        e = "k\015\012";
        clear_cap();
        push_str("hello\015");
        seen = 0;
        cyc = 0;
        while (seen < 2 && cyc < 200) begin
            @(negedge clk);
            if (tx_en) seen++;
            cyc++;
        end
        total++; if (seen !== 2) begin bad++; $display("FAIL midrst_pushes got=%0d exp=2", seen); end
        rst_n = 1'b0;
        #1;
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL midrst_tx_en got=%b exp=0", tx_en); end
        during = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_en) during++;
        end
        total++; if (during !== 0) begin bad++; $display("FAIL midrst_during got=%0d exp=0", during); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        clear_cap();
        push_str("k\015");
        wait_done(e.len(), "midrst");
        total++; if (tx_n !== e.len()) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", tx_n, e.len()); end
        for (int i = 0; i < e.len(); i++) begin
            total++;
            if (txcap[i] !== e[i]) begin bad++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, txcap[i], e[i]); end
        end
    endtask

    task automatic test_protocol();
        total++; if (full_viol !== 0) begin bad++; $display("FAIL proto_tx_when_full got=%0d exp=0", full_viol); end
        total++; if (b2b_viol !== 0) begin bad++; $display("FAIL proto_b2b_pop got=%0d exp=0", b2b_viol); end
        total++; if (pop_err !== 0) begin bad++; $display("FAIL proto_pop_empty got=%0d exp=0", pop_err); end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_backspace();
        test_overflow();
        test_tx_full_hold();
        test_empty_lines();
        test_reset_mid_send();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_line_echo_ctrl.md
UART_LINE_ECHO_CTRL -- requirements
Module: uart_line_echo_ctrl

Interface
REQ-001 The block SHALL have one parameter: LINE_LEN, default 16, maximum characters held in the line buffer (2..256).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have the port rx_data, input, 8 bits: the byte at the head of the UART RX buffer, valid while rx_empty=0 (first-word fall-through).
REQ-005 The block SHALL have the port rx_empty, input, 1 bit: the UART RX buffer is empty.
REQ-006 The block SHALL have the port rx_next, output, 1 bit: a one-cycle pop of the RX buffer head.
REQ-007 The block SHALL have the port tx_data, output, 8 bits: the byte written to the UART TX buffer.
REQ-008 The block SHALL have the port tx_en, output, 1 bit: a one-cycle push of tx_data into the TX buffer.
REQ-009 The block SHALL have the port tx_full, input, 1 bit: the UART TX buffer is full.
REQ-010 The block SHALL have the port busy, output, 1 bit: high in every state except COLLECT.
REQ-011 The block SHALL have the port ovf, output, 1 bit: a one-cycle pulse when a line is flushed because the buffer is full.

Function
REQ-012 The FSM SHALL have the states COLLECT, SEND, SEND_CR and SEND_LF.
REQ-013 COLLECT SHALL behave as follows.
- If rx_empty=0: assert rx_next for exactly one cycle and process rx_data in that same cycle.
- The next pop SHALL be no earlier than 2 cycles later, so the RX buffer can update its head.
REQ-014 Byte processing in COLLECT SHALL be as follows.
- 0x0D (CR): go to SEND; the CR is not stored.
- 0x0A (LF): discard.
- 0x08 (BS): decrement cnt if cnt>0; do not store.
- Any other byte: store it at buf[cnt] and increment cnt.
REQ-015 If storing a byte makes cnt equal LINE_LEN, the block SHALL pulse ovf and go to SEND in the next cycle.
REQ-016 SEND SHALL operate as follows.
- Index idx starts at 0.
- Each cycle with tx_full=0: tx_en=1, tx_data=buf[idx], increment idx.
- When the byte at idx=cnt-1 is pushed: go to SEND_CR.
- If cnt=0 on entry: go directly to SEND_CR.
REQ-017 SEND_CR SHALL push 0x0D when tx_full=0 and then go to SEND_LF; SEND_LF SHALL push 0x0A when tx_full=0, clear cnt and idx, and return to COLLECT.
REQ-018 tx_en SHALL never be asserted in a cycle where tx_full=1; the FSM SHALL stall in place while tx_full=1, holding tx_data unchanged.
REQ-019 rx_next SHALL be 0 in every state except COLLECT; RX bytes arriving during SEND/SEND_CR/SEND_LF SHALL remain in the RX buffer.
REQ-020 rx_next and tx_en SHALL be registered outputs (no combinational path from inputs).
REQ-021 The cnt and idx registers SHALL be clog2(LINE_LEN+1) bits wide; decrement at cnt=0 SHALL saturate at 0.

Reset
REQ-022 While rst_n=0, the block SHALL hold: state=COLLECT, cnt=0, idx=0, rx_next=0, tx_en=0, tx_data=0x00, ovf=0, busy=0.
REQ-023 Buffer contents SHALL be don't-care after reset.
REQ-024 Reset asserted mid-line or mid-SEND SHALL abandon the line immediately, with no further tx_en after rst_n falls.

Verification
REQ-025 Bench: feed "Hi\r" with tx_full=0 -> TX stream 0x48 0x69 0x0D 0x0A; busy returns low after the LF push.
REQ-026 Bench: feed "ab\x08c\r" -> TX 0x61 0x63 0x0D 0x0A.
REQ-027 Bench: feed 16 bytes "0123456789ABCDEF" without CR (LINE_LEN=16) -> ovf pulses once; TX is the 16 bytes, then 0x0D 0x0A.
REQ-028 Bench: hold tx_full=1 for 20 cycles after the first SEND push of "xyz\r" -> no tx_en during the hold; the output is still 0x78 0x79 0x7A 0x0D 0x0A in order, with no duplicates.
REQ-029 Bench: feed "\r" alone and "\x08\r" -> each gives TX 0x0D 0x0A only; cnt never underflows.
REQ-030 Bench: pull rst_n low after 2 bytes of SEND, then release and feed "k\r" -> TX after reset is exactly 0x6B 0x0D 0x0A.
